// File: rtl/ppu_vram_port.sv
// PPU register port: decodes $2000/$2002/$2006/$2007, owns the VRAM pointer and
// write toggle, and sequences single-byte VRAM accesses with the NES read buffer.
module ppu_vram_port #(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned PALETTE_BASE = 14'h3F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_valid,
    output logic        busy,
    output logic [15:0] vram_address,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    input  logic [7:0]  vram_rdata
);

    localparam logic [ADDR_WIDTH-1:0] PAL_BASE = ADDR_WIDTH'(PALETTE_BASE);
    localparam logic [ADDR_WIDTH-1:0] INC_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] INC_ROW  = ADDR_WIDTH'(32);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR      = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_CAP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_toggle;
    logic                  r_inc32;
    logic [7:0]            r_rbuf;
    logic [7:0]            r_dout;
    logic [7:0]            r_wdata;
    logic                  r_we;

    logic                  w_hit;
    logic [2:0]            w_sel;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_ctrl;
    logic                  w_wr_addr;
    logic                  w_rd_stat;
    logic                  w_ready;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic                  w_busy;
    logic                  w_valid;
    logic                  w_step;
    logic                  w_cap;
    logic [ADDR_WIDTH-1:0] w_inc;
    logic                  w_unused;

    // Register window 0x2000-0x3FFF, eight registers mirrored through it.
    assign w_hit     = (cpu_address[15:13] == 3'b001);
    assign w_sel     = cpu_address[2:0];
    assign w_unused  = ^cpu_address[12:3];

    // A write strobe masks a simultaneous read strobe.
    assign w_wr      = cpu_we & w_hit;
    assign w_rd      = cpu_re & ~cpu_we & w_hit;

    assign w_wr_ctrl = w_wr & (w_sel == 3'd0);
    assign w_wr_addr = w_wr & (w_sel == 3'd6);
    assign w_rd_stat = w_rd & (w_sel == 3'd2);

    // RD_CAP only presents the result, so a new access may start there.
    assign w_ready   = (r_state == S_IDLE) | (r_state == S_RD_CAP);
    assign w_acc_wr  = w_wr & (w_sel == 3'd7) & w_ready;
    assign w_acc_rd  = w_rd & (w_sel == 3'd7) & w_ready;

    assign w_inc     = r_inc32 ? INC_ROW : INC_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RD_CAP: begin
                if (w_acc_wr) begin
                    w_state_nxt = S_WR;
                end else if (w_acc_rd) begin
                    w_state_nxt = S_RD_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR:      w_state_nxt = S_IDLE;
            S_RD_WAIT: w_state_nxt = S_RD_CAP;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_step  = 1'b0;
        w_cap   = 1'b0;
        case (r_state)
            S_WR: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            S_RD_WAIT: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                w_cap  = 1'b1;
            end
            S_RD_CAP: begin
                w_valid = 1'b1;
            end
            default: begin
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inc32 <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_inc32 <= cpu_data_in[2];
        end
    end

    // $2006 takes priority over the post-access increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr    <= '0;
            r_toggle <= 1'b0;
        end else if (w_wr_addr) begin
            if (!r_toggle) begin
                r_ptr[ADDR_WIDTH-1:8] <= cpu_data_in[ADDR_WIDTH-9:0];
            end else begin
                r_ptr[7:0] <= cpu_data_in;
            end
            r_toggle <= ~r_toggle;
        end else begin
            if (w_rd_stat) begin
                r_toggle <= 1'b0;
            end
            if (w_step) begin
                r_ptr <= r_ptr + w_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_wdata <= 8'h00;
        end else begin
            r_we <= w_acc_wr;
            if (w_acc_wr) begin
                r_wdata <= cpu_data_in;
            end
        end
    end

    // Palette space bypasses the buffer; the buffer still refills either way.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= 8'h00;
            r_rbuf <= 8'h00;
        end else if (w_cap) begin
            r_dout <= (r_ptr >= PAL_BASE) ? vram_rdata : r_rbuf;
            r_rbuf <= vram_rdata;
        end
    end

    assign vram_address   = 16'(r_ptr);
    assign vram_wdata     = r_wdata;
    assign vram_we        = r_we;
    assign cpu_data_out   = r_dout;
    assign cpu_data_valid = w_valid;
    assign busy           = w_busy;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: a register-level model of the CPU-visible
// behaviour schedules expected outputs per cycle; a compare process checks them.
module tb_ppu_vram_port;

    localparam int NC = 2048;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] cpu_address = 16'h0000;
    logic [7:0]  cpu_data_in = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_valid;
    logic        busy;
    logic [15:0] vram_address;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;

    ppu_vram_port dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_address   (cpu_address),
        .cpu_data_in   (cpu_data_in),
        .cpu_we        (cpu_we),
        .cpu_re        (cpu_re),
        .cpu_data_out  (cpu_data_out),
        .cpu_data_valid(cpu_data_valid),
        .busy          (busy),
        .vram_address  (vram_address),
        .vram_wdata    (vram_wdata),
        .vram_we       (vram_we),
        .vram_rdata    (vram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PPU memory with 1-cycle registered read and a write qualifier held from the last CPU write.
    logic [7:0]  mem [0:16383];
    logic        mem_clr = 1'b0;
    logic        poke_en = 1'b0;
    logic [13:0] poke_a = '0;
    logic [7:0]  poke_d = '0;
    logic [15:0] wq_addr = 16'h0000;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
        end else if (poke_en) begin
            mem[poke_a] <= poke_d;
        end else if (vram_we && wq_addr == 16'h2007) begin
            mem[vram_address[13:0]] <= vram_wdata;
        end
        vram_rdata <= mem[vram_address[13:0]];
        if (cpu_we) wq_addr <= cpu_address;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state and per-cycle expectation schedule
    logic [7:0]  m_mem [0:16383];
    logic [13:0] m_ptr;
    logic        m_w;
    logic        m_inc32;
    logic [7:0]  m_buf;
    int          m_free;

    logic        exp_we    [0:NC-1];
    logic        exp_busy  [0:NC-1];
    logic        exp_valid [0:NC-1];
    logic [15:0] exp_addr  [0:NC-1];
    logic [7:0]  exp_wd    [0:NC-1];
    logic [7:0]  exp_dout  [0:NC-1];

    task automatic clear_sched();
        for (int i = 0; i < NC; i++) begin
            exp_we[i] = 1'b0; exp_busy[i] = 1'b0; exp_valid[i] = 1'b0;
            exp_addr[i] = 16'h0; exp_wd[i] = 8'h0; exp_dout[i] = 8'h0;
        end
    endtask

    task automatic model_reset();
        m_ptr = '0; m_w = 1'b0; m_inc32 = 1'b0; m_buf = 8'h00; m_free = 0;
    endtask

    task automatic model_apply(input logic we, input logic re, input logic [15:0] a,
                               input logic [7:0] d, input int k);
        logic [7:0] v;
        if (a >= 16'h2000 && a <= 16'h3FFF) begin
            if (we) begin
                if (a[2:0] == 3'd0) m_inc32 = d[2];
                else if (a[2:0] == 3'd6) begin
                    if (!m_w) m_ptr[13:8] = d[5:0];
                    else      m_ptr[7:0]  = d;
                    m_w = !m_w;
                end else if (a[2:0] == 3'd7 && k >= m_free) begin
                    exp_we[k+1] = 1'b1; exp_busy[k+1] = 1'b1;
                    exp_addr[k+1] = {2'b00, m_ptr}; exp_wd[k+1] = d;
                    m_mem[m_ptr] = d;
                    m_ptr = m_ptr + (m_inc32 ? 14'd32 : 14'd1);
                    m_free = k + 2;
                end
            end else if (re) begin
                if (a[2:0] == 3'd2) m_w = 1'b0;
                else if (a[2:0] == 3'd7 && k >= m_free) begin
                    v = (m_ptr >= 14'h3F00) ? m_mem[m_ptr] : m_buf;
                    m_buf = m_mem[m_ptr];
                    exp_busy[k+1] = 1'b1;
                    exp_valid[k+2] = 1'b1; exp_dout[k+2] = v;
                    m_ptr = m_ptr + (m_inc32 ? 14'd32 : 14'd1);
                    m_free = k + 2;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && cyc < NC) begin
            check("vram_we", {15'h0, vram_we}, {15'h0, exp_we[cyc]});
            check("busy", {15'h0, busy}, {15'h0, exp_busy[cyc]});
            check("valid", {15'h0, cpu_data_valid}, {15'h0, exp_valid[cyc]});
            check("addr_hi", {14'h0, vram_address[15:14]}, 16'h0);
            if (exp_valid[cyc]) check("dout", {8'h0, cpu_data_out}, {8'h0, exp_dout[cyc]});
            if (exp_we[cyc]) begin
                check("wr_addr", vram_address, exp_addr[cyc]);
                check("wdata", {8'h0, vram_wdata}, {8'h0, exp_wd[cyc]});
            end
        end
    end

    task automatic step(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_we = we; cpu_re = re; cpu_address = a; cpu_data_in = d;
        model_apply(we, re, a, d, cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic set_ptr(input logic [15:0] p);
        wr(16'h2006, p[15:8]);
        wr(16'h2006, p[7:0]);
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
        poke_en = 1'b1; poke_a = a; poke_d = d;
        m_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout"}, {8'h0, cpu_data_out}, 16'h0);
        check({tag, "_valid"}, {15'h0, cpu_data_valid}, 16'h0);
        check({tag, "_busy"}, {15'h0, busy}, 16'h0);
        check({tag, "_we"}, {15'h0, vram_we}, 16'h0);
        check({tag, "_wdata"}, {8'h0, vram_wdata}, 16'h0);
        check({tag, "_addr"}, vram_address, 16'h0);
    endtask

    task automatic check_ptr(input string nm, input logic [15:0] lit);
        check(nm, vram_address, lit);
        check({nm, "_model"}, {2'b00, m_ptr}, lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) m_mem[i] = 8'h00;
        clear_sched();
        model_reset();
        #2;
        reset_n = 1'b0;
        mem_clr = 1'b1;
        #1;
        check_zero_outputs("rst0");
        @(posedge clk); #1;
        mem_clr = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;

        // Address set-up and a single $2007 write
        set_ptr(16'h2108);
        wr(16'h2007, 8'hAB);
        idle(1);
        @(negedge clk);
        check("wr_we", {15'h0, vram_we}, 16'h1);
        check("wr_addr_lit", vram_address, 16'h2108);
        check("wr_data_lit", {8'h0, vram_wdata}, 16'h00AB);
        idle(1);
        @(negedge clk);
        check("wr_we_drop", {15'h0, vram_we}, 16'h0);
        check_ptr("ptr_2109", 16'h2109);

        // 32-increment with wrap past the top of the pointer space
        wr(16'h2000, 8'h04);
        set_ptr(16'h3FF0);
        wr(16'h2007, 8'h5A);
        idle(2);
        @(negedge clk);
        check_ptr("ptr_wrap32", 16'h0010);
        wr(16'h2000, 8'h00);

        // Palette bypass, then a non-palette read shows the refilled buffer
        poke(14'h3F00, 8'h0F);
        set_ptr(16'h3F00);
        rd(16'h2007);
        idle(2);
        @(negedge clk);
        check("pal_dout", {8'h0, cpu_data_out}, 16'h000F);
        set_ptr(16'h0000);
        rd(16'h2007);
        idle(2);
        @(negedge clk);
        check("buf_after_pal", {8'h0, cpu_data_out}, 16'h000F);

        // Reset during RD_WAIT drops the access
        rd(16'h2007);
        idle(1);
        #2;
        reset_n = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b0;
        clear_sched();
        model_reset();
        #1;
        check_zero_outputs("rst_mid");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
        idle(2);
        @(negedge clk);
        check_ptr("ptr_after_rst", 16'h0000);

        // Buffered reads: stale buffer first, then the first location
        poke(14'h2000, 8'h11);
        poke(14'h2001, 8'h22);
        set_ptr(16'h2000);
        rd(16'h2007);
        idle(1);
        rd(16'h2007);
        @(negedge clk);
        check("rd1_valid", {15'h0, cpu_data_valid}, 16'h1);
        check("rd1_dout", {8'h0, cpu_data_out}, 16'h0000);
        idle(2);
        @(negedge clk);
        check("rd2_valid", {15'h0, cpu_data_valid}, 16'h1);
        check("rd2_dout", {8'h0, cpu_data_out}, 16'h0011);
        check_ptr("ptr_2002", 16'h2002);

        // Toggle cleared by $2002, then a strobe while busy is ignored
        wr(16'h2006, 8'h3F);
        rd(16'h2002);
        set_ptr(16'h2000);
        idle(1);
        @(negedge clk);
        check_ptr("ptr_toggle", 16'h2000);
        wr(16'h2007, 8'h55);
        wr(16'h2007, 8'h66);
        idle(2);
        @(negedge clk);
        check_ptr("ptr_busy_ign", 16'h2001);

        // Simultaneous write and read: only the write happens
        step(1'b1, 1'b1, 16'h2007, 8'h77);
        idle(2);
        @(negedge clk);
        check_ptr("ptr_wr_wins", 16'h2002);

        // Out-of-window accesses ignored; mirrored $2006 decodes
        wr(16'h0006, 8'h12);
        wr(16'h4006, 8'h34);
        idle(1);
        @(negedge clk);
        check_ptr("ptr_outside", 16'h2002);
        wr(16'h3FFE, 8'h01);
        wr(16'h200E, 8'h23);
        idle(1);
        @(negedge clk);
        check_ptr("ptr_mirror", 16'h0123);

        // +1 wrap at the top of the space
        set_ptr(16'h3FFF);
        wr(16'h2007, 8'hC3);
        idle(2);
        @(negedge clk);
        check_ptr("ptr_wrap1", 16'h0000);

        // Read back the byte committed at 0x2108
        set_ptr(16'h2108);
        rd(16'h2007);
        idle(1);
        rd(16'h2007);
        idle(2);
        @(negedge clk);
        check("readback", {8'h0, cpu_data_out}, 16'h00AB);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
